// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state encoding and default timing constants for the PUF evaluator.
package puf_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_SETTLE, ST_COMPARE, ST_DONE} state_t;
    localparam int DEF_WINDOW  = 1000;
    localparam int DEF_SETTLE  = 4;
    localparam int DEF_CLR_CYC = 2;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; o_done is high during the last cycle of a loaded interval.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    logic         r_act;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_val;
            r_act <= 1'b1;
        end else if (r_act) begin
            r_act <= r_cnt != '0;
            r_cnt <= r_cnt == '0 ? r_cnt : r_cnt - W'(1);
        end
    end
    assign o_done = r_act && r_cnt == '0;
endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences clear/run/settle/compare over RESP_W ring-oscillator pairs
// and returns the response word through a valid/ready handshake.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int RESP_W  = 8,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int CLR_CYC = DEF_CLR_CYC,
    localparam int PW = RESP_W > 1 ? $clog2(RESP_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       count_a,
    input  logic [31:0]       count_b,
    input  logic              at_max_a,
    input  logic              at_max_b,
    output logic              ro_en,
    output logic              cnt_clr,
    output logic [PW-1:0]     pair_sel,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              err
);
    localparam int MX = WINDOW > SETTLE ? (WINDOW > CLR_CYC ? WINDOW : CLR_CYC)
                                        : (SETTLE > CLR_CYC ? SETTLE : CLR_CYC);
    localparam int TW = $clog2(MX + 1);
    state_t            r_state;
    logic              r_ro_en, r_cnt_clr, r_valid, r_busy, r_err;
    logic [PW-1:0]     r_pair;
    logic [RESP_W-1:0] r_resp;
    logic              w_done, w_load, w_last;
    logic [TW-1:0]     w_val;
    assign w_last = r_pair == PW'(RESP_W - 1);
    // The timer is reloaded on the same edge that enters CLEAR, RUN or SETTLE.
    assign w_load = (r_state == ST_IDLE && start) || (r_state == ST_CLEAR && w_done) ||
                    (r_state == ST_RUN && w_done) || (r_state == ST_COMPARE && !w_last);
    assign w_val  = r_state == ST_CLEAR ? TW'(WINDOW - 1) :
                    r_state == ST_RUN   ? TW'(SETTLE - 1) : TW'(CLR_CYC - 1);
    cycle_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_val),
        .o_done (w_done)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ro_en   <= 1'b0;
            r_cnt_clr <= 1'b1;
            r_pair    <= '0;
            r_resp    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt_clr <= start;
                    r_busy    <= start;
                    if (start) begin
                        r_state <= ST_CLEAR;
                        r_pair  <= '0;
                        r_resp  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_CLEAR: if (w_done) begin
                    r_state   <= ST_RUN;
                    r_cnt_clr <= 1'b0;
                    r_ro_en   <= 1'b1;
                end
                ST_RUN: if (w_done) begin
                    r_state <= ST_SETTLE;
                    r_ro_en <= 1'b0;
                end
                ST_SETTLE: if (w_done) r_state <= ST_COMPARE;
                ST_COMPARE: begin
                    r_resp[r_pair] <= count_a > count_b;
                    if (count_a == count_b || at_max_a || at_max_b) r_err <= 1'b1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_state   <= ST_CLEAR;
                        r_pair    <= r_pair + PW'(1);
                        r_cnt_clr <= 1'b1;
                    end
                end
                ST_DONE: if (resp_ready) begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign ro_en      = r_ro_en;
    assign cnt_clr    = r_cnt_clr;
    assign pair_sel   = r_pair;
    assign resp       = r_resp;
    assign resp_valid = r_valid;
    assign busy       = r_busy;
    assign err        = r_err;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: random and directed requests checked every cycle against a
// cycle-position model of the evaluation schedule.
module tb_puf_eval_ctrl;
    localparam int RW = 4, WIN = 10, ST = 4, CC = 2;
    localparam int PER = CC + WIN + ST + 1, TOT = RW * PER;
    logic clk = 0, rst = 1, start = 0, resp_ready = 0;
    logic [31:0] count_a, count_b;
    logic at_max_a, at_max_b, ro_en, cnt_clr, resp_valid, busy, err;
    logic [1:0] pair_sel;
    logic [RW-1:0] resp;
    logic [31:0] ca[RW], cb[RW];
    logic ma[RW], mb[RW];
    int checks = 0, failures = 0;
    int m_mode = 0, m_n = 0;
    logic [1:0] m_pair = 0;
    logic [RW-1:0] m_resp = 0;
    logic m_err = 0, m_rstf = 1;

    always #5 clk = ~clk;
    assign count_a  = ca[pair_sel];
    assign count_b  = cb[pair_sel];
    assign at_max_a = ma[pair_sel];
    assign at_max_b = mb[pair_sel];

    puf_eval_ctrl #(.RESP_W(RW), .WINDOW(WIN), .SETTLE(ST), .CLR_CYC(CC)) dut (
        .clk(clk), .rst(rst), .start(start), .count_a(count_a), .count_b(count_b),
        .at_max_a(at_max_a), .at_max_b(at_max_b), .ro_en(ro_en), .cnt_clr(cnt_clr),
        .pair_sel(pair_sel), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy), .err(err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 evaluating (m_n cycles since acceptance), 2 waiting for ready.
    always @(posedge clk or posedge rst) begin
        int nn, b;
        if (rst) begin
            m_mode <= 0; m_n <= 0; m_pair <= 0; m_resp <= 0; m_err <= 0; m_rstf <= 1;
        end else begin
            m_rstf <= 0;
            if (m_mode == 0 && start) begin
                m_mode <= 1; m_n <= 0; m_pair <= 0; m_resp <= 0; m_err <= 0;
            end else if (m_mode == 1) begin
                nn = m_n + 1;
                m_n <= nn;
                if (nn % PER == 0) begin
                    b = nn / PER - 1;
                    m_resp[b] <= ca[b] > cb[b];
                    if (ca[b] == cb[b] || ma[b] || mb[b]) m_err <= 1;
                end
                if (nn == TOT) m_mode <= 2;
                else m_pair <= 2'(nn / PER);
            end else if (m_mode == 2 && resp_ready) m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        int ph;
        ph = m_n % PER;
        check("ro_en", 32'(ro_en), 32'(m_mode == 1 && ph >= CC && ph < CC + WIN));
        check("cnt_clr", 32'(cnt_clr), 32'(m_rstf || (m_mode == 1 && ph < CC)));
        check("pair_sel", 32'(pair_sel), 32'(m_pair));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("resp_valid", 32'(resp_valid), 32'(m_mode == 2));
        check("resp", 32'(resp), 32'(m_resp));
        check("err", 32'(err), 32'(m_err));
        check("ro_en_and_cnt_clr", 32'(ro_en && cnt_clr), 0);
    end

    task automatic request(input bit noisy, output int lat);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            if (noisy) start = $urandom_range(0, 7) == 0;
            @(posedge clk); #1;
            lat++;
        end
        start = 0;
    endtask

    task automatic handshake(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic set_pair(input int i, input int a, input int b, input bit xa, input bit xb);
        ca[i] = a; cb[i] = b; ma[i] = xa; mb[i] = xb;
    endtask

    initial begin
        int lat, g, seen;
        logic [RW-1:0] held;
        for (int i = 0; i < RW; i++) set_pair(i, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt_clr", 32'(cnt_clr), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ro_en", 32'(ro_en), 0);
        rst = 0;
        check("cnt_clr_before_edge", 32'(cnt_clr), 1);
        @(posedge clk); #1;
        check("cnt_clr_after_edge", 32'(cnt_clr), 0);

        for (int i = 0; i < RW; i++) set_pair(i, 120, 100, 0, 0);
        request(0, lat);
        check("lat_all_ones", lat, 69);
        check("resp_all_ones", 32'(resp), 32'hf);
        check("err_all_ones", 32'(err), 0);
        handshake(0);
        check("idle_after_ready", 32'(busy), 0);

        set_pair(0, 10, 50, 0, 0); set_pair(1, 20, 60, 0, 0);
        set_pair(2, 77, 77, 0, 0); set_pair(3, 30, 40, 0, 0);
        request(0, lat);
        check("resp_tie", 32'(resp), 0);
        check("err_tie", 32'(err), 1);
        handshake(2);

        set_pair(1, 50, 40, 0, 1); set_pair(2, 5, 9, 0, 0);
        request(0, lat);
        held = resp;
        check("resp_wrap", 32'(resp), 32'b0010);
        check("err_wrap", 32'(err), 1);
        repeat (20) begin @(posedge clk); #1; end
        check("valid_held", 32'(resp_valid), 1);
        check("resp_held", 32'(resp), 32'(held));
        handshake(0);
        check("valid_drop", 32'(resp_valid), 0);

        request(0, lat);
        start = 1; resp_ready = 1;
        @(posedge clk); #1;
        start = 0; resp_ready = 0;
        check("start_with_ready_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("start_dropped", 32'(busy), 0);

        start = 1;
        @(posedge clk); #1;
        start = 0;
        g = 0;
        while (!ro_en && g < 100) begin @(posedge clk); #1; g++; end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        while (!(ro_en && pair_sel == 1) && g < 200) begin @(posedge clk); #1; g++; end
        check("reach_run_pair1", 32'(g < 200), 1);
        #1 rst = 1;
        #1;
        check("async_ro_en", 32'(ro_en), 0);
        check("async_cnt_clr", 32'(cnt_clr), 1);
        check("async_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (100) begin @(posedge clk); #1; if (resp_valid) seen++; end
        check("no_valid_after_rst", seen, 0);

        for (int t = 0; t < 8; t++) begin
            logic [RW-1:0] want;
            logic want_err;
            want = 0; want_err = 0;
            for (int i = 0; i < RW; i++) begin
                int a, b;
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 3) == 0 ? a : $urandom_range(0, 255);
                set_pair(i, a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
                want[i] = a > b;
                want_err = want_err || a == b || ma[i] || mb[i];
            end
            request(1, lat);
            check("rand_lat", lat, 69);
            check("rand_resp", 32'(resp), 32'(want));
            check("rand_err", 32'(err), 32'(want_err));
            handshake($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter RESP_W, default 8, meaning response bits (= RO pairs evaluated) per request.
REQ-002 SHALL have parameter WINDOW, default 1000, meaning clk cycles ro_en is held high per evaluation.
REQ-003 SHALL have parameter SETTLE, default 4, meaning clk cycles (min 2) between ro_en fall and compare.
REQ-004 SHALL have parameter CLR_CYC, default 2, meaning clk cycles cnt_clr is held high per evaluation.
REQ-005 SHALL have port clk  in  1  the single system clock; all logic is on posedge clk.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port start  in  1  request a full RESP_W-bit response.
REQ-008 SHALL have port count_a  in  32  unsigned edge count of RO A of the selected pair.
REQ-009 SHALL have port count_b  in  32  unsigned edge count of RO B of the selected pair.
REQ-010 SHALL have port at_max_a / at_max_b  in  1 each  counter wrap flags of RO A / RO B.
REQ-011 SHALL have port ro_en  out  1  gates the selected ring oscillators.
REQ-012 SHALL have port cnt_clr  out  1  drives the rst input of both edge counters.
REQ-013 SHALL have port pair_sel  out  $clog2(RESP_W)  index of the RO pair under evaluation.
REQ-014 SHALL have ports resp  out  RESP_W, resp_valid  out  1, resp_ready  in  1  (response handshake).
REQ-015 SHALL have ports busy  out  1 and err  out  1 (tie or wrap seen in any bit of current response).

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
REQ-017 IDLE: start=1 SHALL move to CLEAR, set pair_sel=0, clear resp and err; start in any other state SHALL be ignored.
REQ-018 CLEAR: cnt_clr=1 for exactly CLR_CYC cycles, ro_en=0, then RUN.
REQ-019 RUN: ro_en=1 for exactly WINDOW cycles, cnt_clr=0, then SETTLE.
REQ-020 SETTLE: ro_en=0 for exactly SETTLE cycles (counts quasi-static, no synchroniser required), then COMPARE.
REQ-021 COMPARE (1 cycle): resp[pair_sel] SHALL be 1 if count_a > count_b, else 0 (unsigned 32-bit compare).
REQ-022 COMPARE: err SHALL be set (sticky) if count_a == count_b or at_max_a or at_max_b is 1.
REQ-023 COMPARE: if pair_sel == RESP_W-1 go to DONE, else pair_sel increments and go to CLEAR.
REQ-024 DONE: resp_valid=1, resp and err stable; on resp_valid && resp_ready go to IDLE next cycle.
REQ-025 resp_valid SHALL NOT drop before resp_ready is sampled high.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Per-bit latency SHALL be CLR_CYC+WINDOW+SETTLE+1 cycles; full response RESP_W times that, plus 1 cycle for IDLE->CLEAR.
REQ-028 start and resp_ready high in the same DONE cycle SHALL return to IDLE; the start SHALL be dropped.
REQ-029 ro_en and cnt_clr SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 SHALL force, asynchronously: state=IDLE, ro_en=0, cnt_clr=1, pair_sel=0, resp=0, resp_valid=0, busy=0, err=0.
REQ-031 cnt_clr SHALL drop to 0 on the first clk edge after rst deasserts (IDLE value 0).
REQ-032 rst mid-evaluation SHALL discard the partial response; no resp_valid follows.

Structure
REQ-033 Package puf_pkg SHALL hold the FSM state enum and default WINDOW/SETTLE/CLR_CYC constants.
REQ-034 One sub-module, cycle_timer (loadable down-counter with done pulse), SHALL serve CLEAR/RUN/SETTLE timing.

Verification (RESP_W=4, WINDOW=10, SETTLE=4, CLR_CYC=2)
REQ-035 start, model counts a=120,b=100 all pairs -> resp=4'b1111, err=0, resp_valid at cycle 1+4*17=69.
REQ-036 Pair 2 counts a=b=77, others a<b -> resp=4'b0000, err=1.
REQ-037 at_max_b=1 on pair 1, a=50,b=40 -> resp[1]=1, err=1.
REQ-038 resp_ready held 0 for 20 cycles in DONE -> resp_valid and resp stable; ready=1 -> IDLE next cycle, busy=0.
REQ-039 rst asserted during RUN of pair 1 -> immediate ro_en=0, cnt_clr=1, busy=0; no resp_valid afterwards.
REQ-040 start pulsed during RUN -> ignored; exactly one resp_valid per accepted start; ro_en&&cnt_clr never 1.
